// File: rtl/rename_stage_pkg.sv
// Shared rename-stage constants: slot geometry, payload width and tag layout.
package rename_stage_pkg;
  localparam int RP    = 4;       // rename slots per architectural register
  localparam int RB    = 2;       // slot index width, log2(RP)
  localparam int PW    = 64;      // opaque decode payload width
  localparam int NARCH = 32;      // architectural register count
  localparam int TAG_W = 5 + RB;  // physical tag {arch_idx, slot}
endpackage

// File: rtl/rename_stage_free_pick.sv
// Lowest-free-slot priority encoder over one architectural register's used bitmap.
module rn_free_pick #(
  parameter int RP = 4,
  parameter int RB = 2
) (
  input  logic [RP-1:0] usedVec,
  output logic [RB-1:0] freeIdx,
  output logic          hasFree
);

  // Scan from the top down so the lowest clear bit wins.
  always_comb begin
    freeIdx = '0;
    hasFree = 1'b0;
    for (int i = RP - 1; i >= 0; i--) begin
      if (!usedVec[i]) begin
        freeIdx = RB'(i);
        hasFree = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Single-issue rename stage: maps sources through the rename-active pointers, allocates
// a free slot for rd and holds the renamed op in a one-entry valid/ready register.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [4:0]            dec_rd,
  input  logic                  dec_rd_wen,
  input  logic [4:0]            dec_rs1,
  input  logic [4:0]            dec_rs2,
  input  logic [PW-1:0]         dec_info,
  input  logic [RB*NARCH-1:0]   rnAct_X_qout,
  input  logic [RP*NARCH-1:0]   rnBufU_qout,
  output logic [RB*NARCH-1:0]   rnAct_X_dnxt,
  output logic [RP*NARCH-1:0]   rnBufU_rename_set,
  output logic                  rn_valid,
  input  logic                  rn_ready,
  output logic [TAG_W-1:0]      rn_rd_tag,
  output logic [TAG_W-1:0]      rn_rs1_tag,
  output logic [TAG_W-1:0]      rn_rs2_tag,
  output logic [PW-1:0]         rn_info,
  output logic [31:0]           stall_cnt
);

  logic [RP-1:0]    rdUsed;
  logic [RB-1:0]    freeSlot;
  logic             anyFree;
  logic             needAlloc;
  logic             hasFree;
  logic             slotOk;
  logic             accept;
  logic             stallHit;
  logic [RB-1:0]    rs1Slot;
  logic [RB-1:0]    rs2Slot;
  logic [TAG_W-1:0] rdTagNext;

  assign rdUsed = rnBufU_qout[RP*dec_rd +: RP];

  rn_free_pick #(.RP(RP), .RB(RB)) uFreePick (
    .usedVec (rdUsed),
    .freeIdx (freeSlot),
    .hasFree (anyFree)
  );

  // x0 is never renamed, so its sources always read slot 0 and its writes allocate nothing.
  assign needAlloc = dec_rd_wen && (dec_rd != 5'd0);
  assign hasFree   = anyFree || !needAlloc;
  assign slotOk    = !rn_valid || rn_ready;
  assign dec_ready = slotOk && hasFree && !flush && !RST;
  assign accept    = dec_valid && dec_ready;
  assign stallHit  = dec_valid && slotOk && !flush && !RST && needAlloc && !anyFree;

  // Sources see the pointers before this op's own rename, so rs==rd yields the old slot.
  assign rs1Slot   = (dec_rs1 == 5'd0) ? '0 : rnAct_X_qout[RB*dec_rs1 +: RB];
  assign rs2Slot   = (dec_rs2 == 5'd0) ? '0 : rnAct_X_qout[RB*dec_rs2 +: RB];
  assign rdTagNext = needAlloc ? {dec_rd, freeSlot} : '0;

  // Allocation pulse toward phyRegister; pointers pass through unless this op allocates.
  always_comb begin
    rnAct_X_dnxt      = rnAct_X_qout;
    rnBufU_rename_set = '0;
    if (accept && needAlloc) begin
      rnAct_X_dnxt[RB*dec_rd +: RB]         = freeSlot;
      rnBufU_rename_set[RP*dec_rd + freeSlot] = 1'b1;
    end
  end

  // Output pipeline register; flush beats both accept and dispatch handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rn_valid   <= 1'b0;
      rn_rd_tag  <= '0;
      rn_rs1_tag <= '0;
      rn_rs2_tag <= '0;
      rn_info    <= '0;
    end else if (flush) begin
      rn_valid <= 1'b0;
    end else if (accept) begin
      rn_valid   <= 1'b1;
      rn_rd_tag  <= rdTagNext;
      rn_rs1_tag <= {dec_rs1, rs1Slot};
      rn_rs2_tag <= {dec_rs2, rs2Slot};
      rn_info    <= dec_info;
    end else if (rn_ready) begin
      rn_valid <= 1'b0;
    end
  end

  // Saturating count of cycles lost to an exhausted rd slot pool.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (stallHit && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: vector table, directed corner sequences and
// randomized traffic against an array-based reference model.
module tb_rename_stage;
  import rename_stage_pkg::*;

  logic                CLK = 1'b0;
  logic                RST, flush, dec_valid, dec_rd_wen, rn_ready;
  logic [4:0]          dec_rd, dec_rs1, dec_rs2;
  logic [PW-1:0]       dec_info;
  logic [RB*NARCH-1:0] rnAct_X_qout, rnAct_X_dnxt;
  logic [RP*NARCH-1:0] rnBufU_qout, rnBufU_rename_set;
  logic                dec_ready, rn_valid;
  logic [TAG_W-1:0]    rn_rd_tag, rn_rs1_tag, rn_rs2_tag;
  logic [PW-1:0]       rn_info;
  logic [31:0]         stall_cnt;

  logic [RB-1:0] actArr  [NARCH];
  logic [RP-1:0] usedArr [NARCH];

  int nTests = 0;
  int nFail  = 0;

  // reference model of the output register and stall counter
  bit               mValid;
  logic [TAG_W-1:0] mRd, mRs1, mRs2;
  logic [PW-1:0]    mInfo;
  logic [31:0]      mStall;

  always #5 CLK = ~CLK;

  always_comb begin
    rnAct_X_qout = '0;
    rnBufU_qout  = '0;
    for (int i = 0; i < NARCH; i++) begin
      rnAct_X_qout[RB*i +: RB] = actArr[i];
      rnBufU_qout[RP*i +: RP]  = usedArr[i];
    end
  end

  rename_stage dut (
    .CLK(CLK), .RST(RST), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_info(dec_info), .rnAct_X_qout(rnAct_X_qout), .rnBufU_qout(rnBufU_qout),
    .rnAct_X_dnxt(rnAct_X_dnxt), .rnBufU_rename_set(rnBufU_rename_set),
    .rn_valid(rn_valid), .rn_ready(rn_ready), .rn_rd_tag(rn_rd_tag),
    .rn_rs1_tag(rn_rs1_tag), .rn_rs2_tag(rn_rs2_tag), .rn_info(rn_info),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clearArrays();
    for (int i = 0; i < NARCH; i++) begin
      actArr[i]  = '0;
      usedArr[i] = '0;
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_rd_wen = 1'b0; rn_ready = 1'b0;
    dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_info = '0;
    repeat (2) @(posedge CLK);
    mValid = 0; mRd = '0; mRs1 = '0; mRs2 = '0; mInfo = '0; mStall = '0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Compare everything against the model for the current inputs, then advance one edge.
  task automatic modelStep();
    int               freeIdx;
    bit               needA, anyFree, hasF, slotOk, expReady, acc;
    logic [127:0]     expSet;
    logic [63:0]      expDnxt;
    freeIdx = -1;
    for (int j = 0; j < RP; j++)
      if (!usedArr[dec_rd][j] && freeIdx < 0) freeIdx = j;
    needA    = dec_rd_wen && (dec_rd != 0);
    anyFree  = (freeIdx >= 0);
    hasF     = !needA || anyFree;
    slotOk   = !mValid || rn_ready;
    expReady = slotOk && hasF && !flush;
    acc      = dec_valid && expReady;
    expSet   = '0;
    if (acc && needA) expSet[RP*int'(dec_rd) + freeIdx] = 1'b1;
    expDnxt = '0;
    for (int i = 0; i < NARCH; i++)
      expDnxt[RB*i +: RB] = (acc && needA && i == int'(dec_rd)) ? RB'(freeIdx) : actArr[i];
    chk("dec_ready", dec_ready, expReady);
    chk("rename_set", rnBufU_rename_set, expSet);
    chk("act_dnxt", rnAct_X_dnxt, expDnxt);
    chk("rn_valid", rn_valid, mValid);
    chk("stall_cnt", stall_cnt, mStall);
    if (mValid) begin
      chk("rn_rd_tag", rn_rd_tag, mRd);
      chk("rn_rs1_tag", rn_rs1_tag, mRs1);
      chk("rn_rs2_tag", rn_rs2_tag, mRs2);
      chk("rn_info", rn_info, mInfo);
    end
    @(posedge CLK);
    if (dec_valid && slotOk && !flush && needA && !anyFree && mStall != 32'hFFFF_FFFF)
      mStall++;
    if (flush) mValid = 0;
    else if (acc) begin
      mValid = 1;
      mRd    = needA ? {dec_rd, RB'(freeIdx)} : '0;
      mRs1   = {dec_rs1, (dec_rs1 == 0) ? RB'(0) : actArr[dec_rs1]};
      mRs2   = {dec_rs2, (dec_rs2 == 0) ? RB'(0) : actArr[dec_rs2]};
      mInfo  = dec_info;
    end else if (rn_ready) mValid = 0;
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic w,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic rdy, input logic fl);
    @(negedge CLK);
    dec_valid = v; dec_rd = rd; dec_rd_wen = w; dec_rs1 = r1; dec_rs2 = r2;
    rn_ready = rdy; flush = fl; dec_info = {$urandom, $urandom};
    #1;
    modelStep();
  endtask

  typedef struct {
    logic [4:0] rd;
    logic       wen;
    logic [4:0] rs1;
    logic [1:0] act;
    logic [3:0] used;
    logic       expReady;
    int         expSetBit;
    logic [6:0] expRdTag;
    logic [6:0] expRs1Tag;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [127:0] expSet;
    logic [TAG_W-1:0] held;

    vecs[0] = '{5'd5,  1'b1, 5'd5, 2'd1, 4'b0011, 1'b1,  22, 7'd22,  7'd21};
    vecs[1] = '{5'd3,  1'b1, 5'd4, 2'd2, 4'b0000, 1'b1,  12, 7'd12,  7'd18};
    vecs[2] = '{5'd3,  1'b1, 5'd3, 2'd0, 4'b1110, 1'b1,  12, 7'd12,  7'd12};
    vecs[3] = '{5'd3,  1'b1, 5'd1, 2'd3, 4'b0111, 1'b1,  15, 7'd15,  7'd7};
    vecs[4] = '{5'd3,  1'b1, 5'd2, 2'd1, 4'b1111, 1'b0,  -1, 7'd0,   7'd0};
    vecs[5] = '{5'd0,  1'b1, 5'd6, 2'd1, 4'b0000, 1'b1,  -1, 7'd0,   7'd25};
    vecs[6] = '{5'd9,  1'b0, 5'd9, 2'd2, 4'b1111, 1'b1,  -1, 7'd0,   7'd38};
    vecs[7] = '{5'd31, 1'b1, 5'd0, 2'd3, 4'b1011, 1'b1, 126, 7'd126, 7'd0};

    RST = 1'b1;
    clearArrays();
    doReset();

    // reset / idle
    for (int i = 0; i < NARCH; i++) actArr[i] = RB'($urandom);
    #1;
    chk("rst_rn_valid", rn_valid, 1'b0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_rd_tag", rn_rd_tag, 0);
    chk("rst_info", rn_info, 0);
    chk("rst_set", rnBufU_rename_set, 0);
    chk("rst_dnxt", rnAct_X_dnxt, rnAct_X_qout);

    // vector table
    foreach (vecs[k]) begin
      @(negedge CLK);
      for (int i = 0; i < NARCH; i++) begin
        actArr[i]  = vecs[k].act;
        usedArr[i] = '0;
      end
      usedArr[vecs[k].rd] = vecs[k].used;
      dec_valid = 1'b1; rn_ready = 1'b1; flush = 1'b0;
      dec_rd = vecs[k].rd; dec_rd_wen = vecs[k].wen; dec_rs1 = vecs[k].rs1; dec_rs2 = 5'd0;
      #1;
      expSet = '0;
      if (vecs[k].expSetBit >= 0) expSet[vecs[k].expSetBit] = 1'b1;
      chk("tbl_ready", dec_ready, vecs[k].expReady);
      chk("tbl_set", rnBufU_rename_set, expSet);
      chk("tbl_dnxt", rnAct_X_dnxt[RB*vecs[k].rd +: RB],
          (vecs[k].expSetBit >= 0) ? vecs[k].expRdTag[1:0] : vecs[k].act);
      @(posedge CLK);
      #1;
      chk("tbl_rn_valid", rn_valid, vecs[k].expReady);
      if (vecs[k].expReady) begin
        chk("tbl_rd_tag", rn_rd_tag, vecs[k].expRdTag);
        chk("tbl_rs1_tag", rn_rs1_tag, vecs[k].expRs1Tag);
      end
    end

    // slot exhaustion then release
    clearArrays();
    doReset();
    usedArr[7] = 4'b1111;
    repeat (3) drive(1'b1, 5'd7, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0);
    chk("exh_stall3", stall_cnt, 32'd3);
    usedArr[7] = 4'b1101;
    drive(1'b1, 5'd7, 1'b1, 5'd7, 5'd2, 1'b1, 1'b0);
    chk("exh_rd_tag", rn_rd_tag, {5'd7, 2'd1});

    // back-pressure: hold for 4 cycles, then replace on the same edge
    drive(1'b1, 5'd10, 1'b1, 5'd3, 5'd4, 1'b0, 1'b0);
    held = rn_rd_tag;
    repeat (4) drive(1'b1, 5'd11, 1'b1, 5'd5, 5'd6, 1'b0, 1'b0);
    chk("bp_hold", rn_rd_tag, held);
    drive(1'b1, 5'd12, 1'b1, 5'd5, 5'd6, 1'b1, 1'b0);
    chk("bp_replace", rn_rd_tag, {5'd12, 2'd0});

    // flush with a held op and a new op presented
    drive(1'b1, 5'd13, 1'b1, 5'd1, 5'd1, 1'b0, 1'b1);
    chk("flush_valid", rn_valid, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NARCH; i++) begin
        actArr[i]  = RB'($urandom);
        usedArr[i] = ($urandom_range(0, 3) == 0) ? 4'hF : RP'($urandom);
      end
      drive(1'($urandom), 5'($urandom), ($urandom_range(0, 4) != 0),
            5'($urandom), 5'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
